// File: rtl/alarm_scanner.sv
`default_nettype none
// ============================================================================
// Module      : alarm_scanner
// Description : Reader side of the alarm register file. On every minute
//               boundary it walks the seven 13-bit alarm registers, one per
//               cycle, and compares each armed entry with the current time.
//               A match raises and holds the alarm. The alarm is then
//               dismissed by stop, deferred by snooze, or stopped
//               automatically after RING_MINUTES minute ticks.
// Ports       : clk_i          system clock, rising edge
//               rst_ni         asynchronous active-low reset
//               q_r0_i..q_r6_i alarm registers: [12] armed, [11] reserved,
//                              [10:6] hour, [5:0] minute
//               cur_hour_i     current hour (0..23)
//               cur_min_i      current minute (0..59)
//               minute_tick_i  one-cycle pulse on the first cycle of a minute
//               stop_i         one-cycle pulse that dismisses the alarm
//               snooze_i       one-cycle pulse that snoozes the alarm
//               alarm_o        ringing (registered)
//               alarm_idx_o    index of the register that raised the alarm
//               busy_o         high while scanning (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_scanner #(
    parameter int RING_MINUTES   = 5,
    parameter int SNOOZE_MINUTES = 9
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [12:0] q_r0_i,
    input  logic [12:0] q_r1_i,
    input  logic [12:0] q_r2_i,
    input  logic [12:0] q_r3_i,
    input  logic [12:0] q_r4_i,
    input  logic [12:0] q_r5_i,
    input  logic [12:0] q_r6_i,
    input  logic [4:0]  cur_hour_i,
    input  logic [5:0]  cur_min_i,
    input  logic        minute_tick_i,
    input  logic        stop_i,
    input  logic        snooze_i,
    output logic        alarm_o,
    output logic [2:0]  alarm_idx_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RING   = 2'd2,
        S_SNOOZE = 2'd3
    } state_t;

    localparam logic [3:0] RING_LIMIT   = 4'(RING_MINUTES);
    localparam logic [3:0] SNOOZE_LIMIT = 4'(SNOOZE_MINUTES);
    localparam logic [2:0] LAST_IDX     = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  scan_idx_q, scan_idx_d;
    logic [3:0]  ring_cnt_q, ring_cnt_d;
    logic [3:0]  snz_cnt_q, snz_cnt_d;
    logic        pending_q, pending_d;
    logic        alarm_q, alarm_d;
    logic [2:0]  alarm_idx_q, alarm_idx_d;
    logic        busy_q, busy_d;

    logic [12:0] entry;
    logic        match;

    // Registers are read live, so a write landing mid-scan is only seen by
    // indices that have not been visited yet.
    always_comb begin
        entry = 13'd0;
        case (scan_idx_q)
            3'd0:    entry = q_r0_i;
            3'd1:    entry = q_r1_i;
            3'd2:    entry = q_r2_i;
            3'd3:    entry = q_r3_i;
            3'd4:    entry = q_r4_i;
            3'd5:    entry = q_r5_i;
            3'd6:    entry = q_r6_i;
            default: entry = 13'd0;
        endcase
    end

    // Bit 11 is reserved and deliberately left out of the compare.
    assign match = entry[12] && (entry[10:6] == cur_hour_i) && (entry[5:0] == cur_min_i);

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        ring_cnt_d  = ring_cnt_q;
        snz_cnt_d   = snz_cnt_q;
        pending_d   = pending_q;
        alarm_d     = alarm_q;
        alarm_idx_d = alarm_idx_q;

        case (state_q)
            S_IDLE: begin
                alarm_d = 1'b0;
                if (minute_tick_i || pending_q) begin
                    state_d    = S_SCAN;
                    scan_idx_d = 3'd0;
                    pending_d  = 1'b0;
                end
            end
            S_SCAN: begin
                // A tick arriving mid-scan is remembered so the new minute
                // still gets a full pass once this one finishes.
                if (minute_tick_i) begin
                    pending_d = 1'b1;
                end
                if (match) begin
                    state_d     = S_RING;
                    alarm_d     = 1'b1;
                    alarm_idx_d = scan_idx_q;
                    ring_cnt_d  = 4'd0;
                end else if (scan_idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + 3'd1;
                end
            end
            S_RING: begin
                alarm_d = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                    alarm_d = 1'b0;
                end else if (snooze_i) begin
                    state_d   = S_SNOOZE;
                    alarm_d   = 1'b0;
                    snz_cnt_d = 4'd0;
                end else if (minute_tick_i) begin
                    ring_cnt_d = ring_cnt_q + 4'd1;
                    if (ring_cnt_d == RING_LIMIT) begin
                        state_d = S_IDLE;
                        alarm_d = 1'b0;
                    end
                end
            end
            S_SNOOZE: begin
                alarm_d = 1'b0;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (minute_tick_i) begin
                    snz_cnt_d = snz_cnt_q + 4'd1;
                    if (snz_cnt_d == SNOOZE_LIMIT) begin
                        state_d    = S_RING;
                        alarm_d    = 1'b1;
                        ring_cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                alarm_d = 1'b0;
            end
        endcase

        busy_d = (state_d == S_SCAN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            scan_idx_q  <= 3'd0;
            ring_cnt_q  <= 4'd0;
            snz_cnt_q   <= 4'd0;
            pending_q   <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_idx_q <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            pending_q   <= pending_d;
            alarm_q     <= alarm_d;
            alarm_idx_q <= alarm_idx_d;
            busy_q      <= busy_d;
        end
    end

    assign alarm_o     = alarm_q;
    assign alarm_idx_o = alarm_idx_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_scanner
// Description : Directed self-checking bench for alarm_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_scanner;

    logic        clk_i;
    logic        rst_ni;
    logic [12:0] q_r0_i, q_r1_i, q_r2_i, q_r3_i, q_r4_i, q_r5_i, q_r6_i;
    logic [4:0]  cur_hour_i;
    logic [5:0]  cur_min_i;
    logic        minute_tick_i;
    logic        stop_i;
    logic        snooze_i;
    logic        alarm_o;
    logic [2:0]  alarm_idx_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    alarm_scanner #(
        .RING_MINUTES   (5),
        .SNOOZE_MINUTES (9)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .q_r0_i        (q_r0_i),
        .q_r1_i        (q_r1_i),
        .q_r2_i        (q_r2_i),
        .q_r3_i        (q_r3_i),
        .q_r4_i        (q_r4_i),
        .q_r5_i        (q_r5_i),
        .q_r6_i        (q_r6_i),
        .cur_hour_i    (cur_hour_i),
        .cur_min_i     (cur_min_i),
        .minute_tick_i (minute_tick_i),
        .stop_i        (stop_i),
        .snooze_i      (snooze_i),
        .alarm_o       (alarm_o),
        .alarm_idx_o   (alarm_idx_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_tick();
        minute_tick_i = 1'b1;
        step(1);
        minute_tick_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze_i = 1'b1;
        step(1);
        snooze_i = 1'b0;
    endtask

    logic [12:0] e0730, e0600, e0600_off;

    initial begin
        e0730     = {1'b1, 1'b0, 5'd7, 6'd30};
        e0600     = {1'b1, 1'b0, 5'd6, 6'd0};
        e0600_off = {1'b0, 1'b0, 5'd6, 6'd0};

        rst_ni = 1'b0;
        {q_r0_i, q_r1_i, q_r2_i, q_r3_i, q_r4_i, q_r5_i, q_r6_i} = '0;
        cur_hour_i = 5'd0; cur_min_i = 6'd0;
        minute_tick_i = 1'b0; stop_i = 1'b0; snooze_i = 1'b0;
        #12;
        check("reset_alarm", int'(alarm_o), 0);
        check("reset_idx",   int'(alarm_idx_o), 0);
        check("reset_busy",  int'(busy_o), 0);
        rst_ni = 1'b1;
        step(2);

        // 1: single match at index 3, alarm four edges after the tick
        q_r3_i = e0730; cur_hour_i = 5'd7; cur_min_i = 6'd30;
        pulse_tick();
        check("t1_busy_start", int'(busy_o), 1);
        step(3);
        check("t1_alarm_early", int'(alarm_o), 0);
        check("t1_busy_mid",    int'(busy_o), 1);
        step(1);
        check("t1_alarm", int'(alarm_o), 1);
        check("t1_idx",   int'(alarm_idx_o), 3);
        check("t1_busy_end", int'(busy_o), 0);
        pulse_stop();
        check("t1_stop", int'(alarm_o), 0);

        // 1b: no match -> busy for exactly 7 cycles
        cur_hour_i = 5'd8; cur_min_i = 6'd0;
        step(1);
        pulse_tick();
        step(6);
        check("t1b_busy_last", int'(busy_o), 1);
        step(1);
        check("t1b_busy_done", int'(busy_o), 0);
        check("t1b_alarm",     int'(alarm_o), 0);
        check("t1b_idx_held",  int'(alarm_idx_o), 3);

        // 2: lowest armed index wins; unarmed entry ignored
        q_r3_i = '0;
        q_r1_i = e0600; q_r5_i = e0600; q_r4_i = e0600_off;
        cur_hour_i = 5'd6; cur_min_i = 6'd0;
        pulse_tick();
        step(2);
        check("t2_alarm", int'(alarm_o), 1);
        check("t2_idx",   int'(alarm_idx_o), 1);
        pulse_stop();
        q_r1_i = '0; q_r5_i = '0;
        pulse_tick();
        step(7);
        check("t2_unarmed_alarm", int'(alarm_o), 0);
        check("t2_unarmed_busy",  int'(busy_o), 0);

        // 3: auto-stop on the 5th ring tick
        q_r2_i = e0600;
        pulse_tick();
        step(3);
        check("t3_alarm", int'(alarm_o), 1);
        check("t3_idx",   int'(alarm_idx_o), 2);
        for (int i = 1; i <= 4; i++) begin
            pulse_tick();
            check($sformatf("t3_ring_tick%0d", i), int'(alarm_o), 1);
            check($sformatf("t3_no_scan%0d", i), int'(busy_o), 0);
            step(1);
        end
        pulse_tick();
        check("t3_autostop", int'(alarm_o), 0);
        step(1);
        check("t3_idle_busy", int'(busy_o), 0);

        // 4: snooze for 9 ticks, re-ring same index, then stop
        pulse_tick();
        step(3);
        check("t4_alarm", int'(alarm_o), 1);
        pulse_snooze();
        check("t4_snoozed", int'(alarm_o), 0);
        check("t4_idx_held", int'(alarm_idx_o), 2);
        pulse_snooze();
        check("t4_snooze_ignored", int'(alarm_o), 0);
        for (int i = 1; i <= 8; i++) begin
            pulse_tick();
            check($sformatf("t4_snz_tick%0d", i), int'(alarm_o), 0);
            step(1);
        end
        pulse_tick();
        check("t4_rering", int'(alarm_o), 1);
        check("t4_rering_idx", int'(alarm_idx_o), 2);
        pulse_stop();
        check("t4_stop", int'(alarm_o), 0);

        // 5: stop beats snooze; tick then starts a scan (so state was IDLE)
        pulse_tick();
        step(3);
        check("t5_alarm", int'(alarm_o), 1);
        stop_i = 1'b1; snooze_i = 1'b1;
        step(1);
        stop_i = 1'b0; snooze_i = 1'b0;
        check("t5_both_alarm", int'(alarm_o), 0);
        pulse_tick();
        check("t5_idle_scan", int'(busy_o), 1);
        step(3);
        pulse_stop();

        // 5b: tick during SCAN causes one rescan
        q_r2_i = '0;
        pulse_tick();           // edge 0
        step(2);                // edges 1,2
        pulse_tick();           // edge 3, mid-scan
        step(3);                // edges 4..6
        check("t5b_scan1_busy", int'(busy_o), 1);
        step(1);                // edge 7: scan 1 done
        check("t5b_scan1_done", int'(busy_o), 0);
        step(1);                // edge 8: rescan
        check("t5b_rescan", int'(busy_o), 1);
        step(6);
        check("t5b_rescan_last", int'(busy_o), 1);
        step(1);
        check("t5b_rescan_done", int'(busy_o), 0);
        step(2);
        check("t5b_no_third", int'(busy_o), 0);

        // 6: asynchronous reset mid-RING, no edge needed
        q_r6_i = e0600;
        pulse_tick();
        step(7);
        check("t6_alarm", int'(alarm_o), 1);
        check("t6_idx",   int'(alarm_idx_o), 6);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_alarm", int'(alarm_o), 0);
        check("t6_rst_idx",   int'(alarm_idx_o), 0);
        check("t6_rst_busy",  int'(busy_o), 0);
        #3 rst_ni = 1'b1;
        step(2);
        check("t6_after_rst", int'(alarm_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
